empacotador_matriz: RTL and testbench

Stream-to-matrix packer that feeds the matrix datapath blocks. It accepts signed 8-bit elements one per handshake in row-major order and assembles DIM×DIM of them into the packed matrix bus used by the transposition and arithmetic blocks. It presents each complete matrix on a valid/ready output and double-buffers (assembly register plus output register) so input streaming continues while the consumer stalls.

---
 rtl/empacotador_matriz.sv | 133 +++++++++++++
 tb/tb_empacotador_matriz.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/empacotador_matriz.sv
// Stream-to-matrix packer: gathers DIM*DIM signed elements in row-major order
// and presents them as one packed bus, with an assembly stage and an output stage.
module empacotador_matriz #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ELEM_W-1:0]           in_elem,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [ELEM_W*DIM*DIM-1:0]   matriz_A,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err_frame
);

  localparam int N     = DIM * DIM;
  localparam int W     = ELEM_W * N;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     asm_q, asm_d;
  logic [W-1:0]     mat_q, mat_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [W-1:0]     asm_wr;
  logic             accept;
  logic             out_free;
  logic             out_hs;

  // in_ready comes from registered state only; reset gates it so nothing is taken mid-reset
  assign in_ready  = (state_q == COLLECT) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign matriz_A  = mat_q;
  assign out_valid = out_valid_q;
  assign err_frame = err_q;

  // Assembly image with the incoming element dropped into the current slot
  always_comb begin
    asm_wr = asm_q;
    asm_wr[idx_q*ELEM_W +: ELEM_W] = in_elem;
  end

  // Next-state logic for the packer FSM, index, buffers and framing flag
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    mat_d   = mat_q;
    err_d   = err_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            // A full matrix without its in_last marker is still emitted, but flagged
            asm_d = asm_wr;
            idx_d = {IDX_W{1'b0}};
            if (!in_last) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (out_free) begin
              mat_d       = asm_wr;
              out_valid_d = 1'b1;
              state_d     = COLLECT;
            end else begin
              state_d = FULL;
            end
          end else if (in_last) begin
            idx_d = {IDX_W{1'b0}};
            err_d = 1'b1;
          end else begin
            asm_d = asm_wr;
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      FULL: begin
        if (out_free) begin
          mat_d       = asm_q;
          out_valid_d = 1'b1;
          state_d     = COLLECT;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      idx_q       <= {IDX_W{1'b0}};
      asm_q       <= {W{1'b0}};
      mat_q       <= {W{1'b0}};
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      mat_q       <= mat_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_empacotador_matriz.sv
// Directed + randomized bench for empacotador_matriz, checked against a frame-queue
// reference model that rebuilds each matrix from the accepted element stream.
module tb_empacotador_matriz;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int N      = DIM * DIM;
  localparam int W      = ELEM_W * N;

  logic              clk = 1'b0;
  logic              reset;
  logic [ELEM_W-1:0] in_elem;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [W-1:0]      matriz_A;
  logic              out_valid;
  logic              out_ready;
  logic              err_frame;

  empacotador_matriz #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_elem   (in_elem),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .matriz_A  (matriz_A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  logic [ELEM_W-1:0] frame_q[$];
  logic [W-1:0]      exp_q[$];
  logic              err_m = 1'b0;

  // Last sampled DUT values
  logic         s_ir, s_ov, s_err;
  logic [W-1:0] s_mat;
  logic [W-1:0] last_mat = '0;
  logic [W-1:0] prev_mat = '0;
  logic         prev_stall = 1'b0;
  logic         acc_s = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample just after, advance the reference model
  task automatic cycle(input logic v, input logic [ELEM_W-1:0] e, input logic l,
                       input logic r, input logic rst);
    logic         ohs;
    logic [W-1:0] m;
    @(negedge clk);
    reset = rst; in_valid = v; in_elem = e; in_last = l; out_ready = r;
    #1;
    cyc++;
    s_ir = in_ready; s_ov = out_valid; s_mat = matriz_A; s_err = err_frame;
    if (rst) begin
      check("ir_in_reset", W'(s_ir), W'(1'b0));
      frame_q.delete();
      exp_q.delete();
      err_m      = 1'b0;
      prev_stall = 1'b0;
      acc_s      = 1'b0;
      return;
    end
    check("err_frame", W'(s_err), W'(err_m));
    if (prev_stall) check("hold_stable", s_mat, prev_mat);
    acc_s = v && s_ir;
    ohs   = s_ov && r;
    if (ohs) begin
      check("out_expected", W'(exp_q.size() > 0), W'(1'b1));
      if (exp_q.size() > 0) begin
        check("matrix", s_mat, exp_q.pop_front());
        last_mat = s_mat;
      end
    end
    if (acc_s) begin
      frame_q.push_back(e);
      if (frame_q.size() == N) begin
        m = '0;
        for (int k = 0; k < N; k++) m[k*ELEM_W +: ELEM_W] = frame_q[k];
        exp_q.push_back(m);
        if (!l) err_m = 1'b1;
        frame_q.delete();
      end else if (l) begin
        err_m = 1'b1;
        frame_q.delete();
      end
    end
    prev_stall = s_ov && !r;
    prev_mat   = s_mat;
  endtask

  task automatic send(input logic [ELEM_W-1:0] e, input logic l, input logic r, input int gap_pct);
    for (int g = 0; g < 4; g++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) cycle(1'b0, ELEM_W'($urandom), 1'b0, r, 1'b0);
    end
    for (int t = 0; t < 60; t++) begin
      cycle(1'b1, e, l, r, 1'b0);
      if (acc_s) return;
    end
    check("send_timeout", W'(acc_s), W'(1'b1));
  endtask

  // Stream elements 0..cnt-1 of m; in_last asserted at index last_at (-1 = never)
  task automatic send_frame(input logic [W-1:0] m, input int cnt, input int last_at,
                            input logic r, input int gap_pct);
    for (int k = 0; k < cnt; k++) send(m[k*ELEM_W +: ELEM_W], (k == last_at), r, gap_pct);
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0) return;
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    check("drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  function automatic logic [W-1:0] rand_mat();
    logic [W-1:0] m;
    for (int k = 0; k < N; k++) m[k*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
    return m;
  endfunction

  logic [W-1:0] ma, mb, mc;
  int           c0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_elem = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ir_after_reset", W'(s_ir), W'(1'b1));
    check("ov_reset", W'(s_ov), W'(1'b0));
    check("mat_reset", s_mat, W'(0));

    // Basic frame: elem k = k
    for (int k = 0; k < N; k++) ma[k*ELEM_W +: ELEM_W] = ELEM_W'(k);
    send_frame(ma, N, N - 1, 1'b1, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ov_latency", W'(s_ov), W'(1'b1));
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ov_one_cycle", W'(s_ov), W'(1'b0));
    check("basic_lo", W'(last_mat[7:0]), W'(8'd0));
    check("basic_hi", W'(last_mat[199:192]), W'(8'd24));
    check("basic_err", W'(s_err), W'(1'b0));

    // Signed values
    ma = '0;
    ma[7:0] = 8'h80; ma[103:96] = 8'h7F; ma[199:192] = 8'hFF;
    send_frame(ma, N, N - 1, 1'b1, 0);
    drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("signed_0", W'(last_mat[7:0]), W'(8'h80));
    check("signed_12", W'(last_mat[103:96]), W'(8'h7F));
    check("signed_24", W'(last_mat[199:192]), W'(8'hFF));

    // Throughput: two back-to-back frames in exactly 2*N cycles
    c0 = cyc;
    send_frame(rand_mat(), N, N - 1, 1'b1, 0);
    send_frame(rand_mat(), N, N - 1, 1'b1, 0);
    check("throughput", W'(cyc - c0), W'(2 * N));
    drain();

    // Backpressure and double buffer
    ma = rand_mat();
    mb = rand_mat();
    send_frame(ma, N, N - 1, 1'b0, 0);
    send_frame(mb, N, N - 1, 1'b0, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ir_full", W'(s_ir), W'(1'b0));
    check("hold_A", s_mat, ma);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ir_still_full", W'(s_ir), W'(1'b0));
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("deliver_A", last_mat, ma);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("B_next", W'(s_ov), W'(1'b1));
    check("deliver_B", last_mat, mb);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ir_after_B", W'(s_ir), W'(1'b1));
    check("ov_after_B", W'(s_ov), W'(1'b0));

    // Early in_last at k = 9
    ma = rand_mat();
    send_frame(ma, 10, 9, 1'b1, 0);
    for (int t = 0; t < 3; t++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("early_no_ov", W'(s_ov), W'(1'b0));
    end
    check("early_err", W'(s_err), W'(1'b1));
    mb = rand_mat();
    send_frame(mb, N, N - 1, 1'b1, 0);
    drain();
    check("early_next", last_mat, mb);

    // Missing in_last
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("err_cleared", W'(s_err), W'(1'b0));
    ma = rand_mat();
    send_frame(ma, N, -1, 1'b1, 0);
    drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("missing_mat", last_mat, ma);
    check("missing_err", W'(s_err), W'(1'b1));
    mb = rand_mat();
    send_frame(mb, N, N - 1, 1'b1, 0);
    drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("missing_next", last_mat, mb);
    check("missing_err_sticky", W'(s_err), W'(1'b1));

    // Reset mid-frame, then a gapped frame
    send_frame(rand_mat(), 12, -1, 1'b1, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("rst_ov", W'(s_ov), W'(1'b0));
    check("rst_err", W'(s_err), W'(1'b0));
    mc = rand_mat();
    send_frame(mc, N, N - 1, 1'b1, 40);
    drain();
    check("rst_next", last_mat, mc);
    send_frame(mc, N, N - 1, 1'b0, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("no_gap_same", s_mat, mc);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
